cdr_period_track: RTL and testbench
===================================

CDR_PERIOD_TRACK -- requirements
Module: cdr_period_track

Interface
- REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  - W, 6, period/counter width.
  - NOM, 25, nominal sample period in i_clk cycles.
  - MAX_DEV, 2, maximum period deviation from NOM.
  - STEP, 1, period change per adjustment.
  - VOTE_TH, 2, vote magnitude that triggers an adjustment.
  - LOCK_N, 8, consecutive unadjusted intervals before lock.
- REQ-002 Ports SHALL be, one per line as name direction width meaning:
  - i_clk in 1 clock.
  - i_rst in 1 reset, asynchronous, active-high.
  - i_resync in 1 synchronous restart.
  - i_T in 1 data transition detected this cycle.
  - i_E in 1 phase decision qualifying i_T (1 = early, 0 = late).
  - o_nb_P out W current sample period.
  - o_sample out 1 one-cycle sampling strobe.
  - o_adj_up out 1 period increased this cycle.
  - o_adj_dn out 1 period decreased this cycle.
  - o_lock out 1 tracking locked.
- REQ-003 Elaboration SHALL fail unless NOM+MAX_DEV < 2^W, NOM-MAX_DEV >= 2, STEP >= 1, VOTE_TH >= 1, and LOCK_N >= 1.

Function
- REQ-004 The interval counter SHALL count 0..o_nb_P-1 and wrap to 0; o_sample SHALL be 1 exactly in the cycle where count == o_nb_P-1.
- REQ-005 o_nb_P SHALL change only in an o_sample cycle; the new value SHALL govern the next interval, so count < o_nb_P always holds.
- REQ-006 The vote accumulator SHALL be signed with range [-VOTE_TH, +VOTE_TH]:
  - i_T with i_E=1 adds +1.
  - i_T with i_E=0 adds -1.
  - Updates saturate at the range limits.
- REQ-007 At each o_sample, the decision SHALL use the accumulator value before this cycle's i_T update:
  - vote >= +VOTE_TH: period increases by STEP.
  - vote <= -VOTE_TH: period decreases by STEP.
  - otherwise: no change.
- REQ-008 Period results SHALL clamp to [NOM-MAX_DEV, NOM+MAX_DEV].
- REQ-009 o_adj_up and o_adj_dn SHALL pulse for one cycle, coincident with o_sample, only when o_nb_P actually changes. There is no pulse when already at a bound.
- REQ-010 After any threshold decision, including a clamped one, the accumulator SHALL reload with only this cycle's i_T contribution (0 or ±1). Without a decision it SHALL retain its value plus that contribution.
- REQ-011 Lock counter:
  - Saturating; increments on each o_sample without an o_nb_P change.
  - Clears on each change.
  - o_lock = 1 while the count >= LOCK_N.
- REQ-012 i_resync SHALL be evaluated in the cycle it is high, and the next cycle SHALL show:
  - o_nb_P = NOM, count = 0, vote = 0, lock count = 0.
  - o_lock = 0, o_sample = 0, o_adj_up = 0, o_adj_dn = 0.
  - i_resync SHALL override i_T and the strobe decision in that cycle.
- REQ-013 i_T SHALL be ignored while i_resync = 1.

Reset
- REQ-014 i_rst=1 SHALL asynchronously force:
  - o_nb_P = NOM, count = 0, vote = 0, lock count = 0.
  - o_sample = 0, o_adj_up = 0, o_adj_dn = 0, o_lock = 0.
- REQ-015 After i_rst deasserts, the first o_sample SHALL occur at the NOM-th rising edge. A reset mid-interval SHALL discard the partial interval and all votes.

Configuration
- REQ-016 With macro CDR_TRACK_STATS_EN defined:
  - An output o_adj_cnt (16 bits) SHALL exist.
  - It counts o_adj_up|o_adj_dn pulses, saturating at 16'hFFFF.
  - i_rst and i_resync clear it.
- Without the macro, the port and the counter SHALL be absent.

Structure
- REQ-017 Package cdr_pkg SHALL hold:
  - default constants CDR_NOM_P=25, CDR_MAX_DEV=2, CDR_VOTE_TH=2;
  - typedef adj_e {ADJ_NONE, ADJ_UP, ADJ_DN}.
- REQ-018 Sub-module cdr_vote_filter SHALL hold the accumulator and decision logic (REQ-006, REQ-007, REQ-010) and return adj_e. The period clamp, counter and lock logic SHALL stay in cdr_period_track.

Verification (defaults)
- REQ-019 Release reset with i_T=0: o_sample at cycles 25, 50, 75; o_nb_P stays 25; o_lock=1 from the 8th strobe on.
- REQ-020 Two i_T/i_E=1 pulses in interval 1 → at strobe 1: o_nb_P=26 and o_adj_up=1; next strobe occurs 26 cycles later; o_lock=0.
- REQ-021 Early votes every interval → o_nb_P goes 26, then 27, then stays 27; no o_adj_up at the third strobe; vote is cleared.
- REQ-022 Alternating early/late i_T pulses → vote stays within ±1, no adjustment, o_nb_P=25, lock reached.
- REQ-023 Two late votes followed by an i_T/i_E=0 pulse exactly on the strobe cycle → o_nb_P=24, o_adj_dn=1, post-strobe vote = -1.
- REQ-024 With o_nb_P=24, assert i_resync mid-interval → next cycle o_nb_P=25, count 0, o_lock=0; next o_sample 25 cycles later.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared defaults and the adjustment type for the CDR sample-period tracker.
package cdr_pkg;

    localparam int CDR_NOM_P   = 25;
    localparam int CDR_MAX_DEV = 2;
    localparam int CDR_VOTE_TH = 2;

    typedef enum logic [1:0] {
        ADJ_NONE,
        ADJ_UP,
        ADJ_DN
    } adj_e;

endpackage

// File: rtl/cdr_vote_filter.sv
// Saturating early/late vote accumulator; emits a period adjustment request on each strobe.
module cdr_vote_filter
    import cdr_pkg::*;
#(
    parameter int VOTE_TH = CDR_VOTE_TH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_resync,
    input  logic i_T,
    input  logic i_E,
    input  logic i_strobe,
    output adj_e o_adj
);

    localparam int VW = $clog2(VOTE_TH + 1) + 1;

    logic signed [VW-1:0] r_vote;
    int                   w_contrib;
    int                   w_sum;
    int                   w_next;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        o_adj     = ADJ_NONE;
        w_contrib = 0;
        w_sum     = 0;
        w_next    = 0;

        // The decision looks at the stored vote only; this cycle's transition is not yet counted.
        if (i_strobe) begin
            if (int'(r_vote) >= VOTE_TH)       o_adj = ADJ_UP;
            else if (int'(r_vote) <= -VOTE_TH) o_adj = ADJ_DN;
        end

        if (i_T) w_contrib = i_E ? 1 : -1;

        w_sum = int'(r_vote) + w_contrib;
        if (w_sum > VOTE_TH)       w_sum = VOTE_TH;
        else if (w_sum < -VOTE_TH) w_sum = -VOTE_TH;

        w_next = (o_adj != ADJ_NONE) ? w_contrib : w_sum;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            r_vote <= '0;
        end else if (i_resync) begin
            r_vote <= '0;
        end else begin
            r_vote <= VW'(w_next);
        end
    end

endmodule

// File: rtl/cdr_period_track.sv
// CDR sample-period tracker: interval counter, clamped period adjustment and lock detection.
// Defining CDR_TRACK_STATS_EN adds the o_adj_cnt adjustment counter output.
module cdr_period_track
    import cdr_pkg::*;
#(
    parameter int W       = 6,
    parameter int NOM     = CDR_NOM_P,
    parameter int MAX_DEV = CDR_MAX_DEV,
    parameter int STEP    = 1,
    parameter int VOTE_TH = CDR_VOTE_TH,
    parameter int LOCK_N  = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_resync,
    input  logic         i_T,
    input  logic         i_E,
    output logic [W-1:0] o_nb_P,
    output logic         o_sample,
    output logic         o_adj_up,
    output logic         o_adj_dn,
    output logic         o_lock
`ifdef CDR_TRACK_STATS_EN
    ,
    output logic [15:0]  o_adj_cnt
`endif
);

    localparam int P_MIN = NOM - MAX_DEV;
    localparam int P_MAX = NOM + MAX_DEV;
    localparam int LW    = $clog2(LOCK_N + 1);

    if ((P_MAX >= (1 << W)) || (P_MIN < 2) || (STEP < 1) || (VOTE_TH < 1) || (LOCK_N < 1)) begin : g_bad_params
        $error("cdr_period_track: illegal parameter combination");
    end

    logic [W-1:0]  r_count;
    logic [W-1:0]  r_nb_P;
    logic [LW-1:0] r_lock_cnt;
    logic          w_strobe;
    logic          w_changed;
    adj_e          w_adj;
    logic [W-1:0]  w_next_p;
    int            w_cand;

    assign o_sample = (r_count == r_nb_P - W'(1));
    assign w_strobe = o_sample && !i_resync;

    cdr_vote_filter #(
        .VOTE_TH(VOTE_TH)
    ) u_vote (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_resync(i_resync),
        .i_T     (i_T),
        .i_E     (i_E),
        .i_strobe(w_strobe),
        .o_adj   (w_adj)
    );

    always_comb begin
        w_cand = int'(r_nb_P);
        case (w_adj)
            ADJ_UP:  w_cand = int'(r_nb_P) + STEP;
            ADJ_DN:  w_cand = int'(r_nb_P) - STEP;
            default: w_cand = int'(r_nb_P);
        endcase
        if (w_cand > P_MAX)      w_cand = P_MAX;
        else if (w_cand < P_MIN) w_cand = P_MIN;
        w_next_p = W'(w_cand);
    end

    // A request that lands on a bound is absorbed by the clamp and produces no pulse.
    assign w_changed = (w_next_p != r_nb_P);
    assign o_adj_up  = (w_adj == ADJ_UP) && w_changed;
    assign o_adj_dn  = (w_adj == ADJ_DN) && w_changed;
    assign o_nb_P    = r_nb_P;
    assign o_lock    = (r_lock_cnt >= LW'(LOCK_N));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= '0;
            r_nb_P     <= W'(NOM);
            r_lock_cnt <= '0;
        end else if (i_resync) begin
            r_count    <= '0;
            r_nb_P     <= W'(NOM);
            r_lock_cnt <= '0;
        end else if (o_sample) begin
            r_count <= '0;
            r_nb_P  <= w_next_p;
            if (w_changed)                       r_lock_cnt <= '0;
            else if (r_lock_cnt < LW'(LOCK_N))   r_lock_cnt <= r_lock_cnt + LW'(1);
        end else begin
            r_count <= r_count + W'(1);
        end
    end

`ifdef CDR_TRACK_STATS_EN
    logic [15:0] r_adj_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_adj_cnt <= '0;
        end else if (i_resync) begin
            r_adj_cnt <= '0;
        end else if ((o_adj_up || o_adj_dn) && (r_adj_cnt != 16'hFFFF)) begin
            r_adj_cnt <= r_adj_cnt + 16'd1;
        end
    end

    assign o_adj_cnt = r_adj_cnt;
`endif

endmodule

// File: tb/tb_cdr_period_track.sv
// Self-checking bench for cdr_period_track: directed scenarios plus biased random traffic
// against an integer reference model of interval length, votes and lock progress.
module tb_cdr_period_track;

    localparam int W       = 6;
    localparam int NOM     = 25;
    localparam int MAX_DEV = 2;
    localparam int STEP    = 1;
    localparam int VOTE_TH = 2;
    localparam int LOCK_N  = 8;
    localparam int P_MIN   = NOM - MAX_DEV;
    localparam int P_MAX   = NOM + MAX_DEV;

    logic         clk = 1'b0;
    logic         rst;
    logic         resync;
    logic         t_in;
    logic         e_in;
    logic [W-1:0] nb_p;
    logic         sample;
    logic         adj_up;
    logic         adj_dn;
    logic         lock;
`ifdef CDR_TRACK_STATS_EN
    logic [15:0]  adj_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_pos;
    int m_p;
    int m_vote;
    int m_lock;
    int m_adj;
    int cyc;
    bit last_sample;
    bit last_up;
    bit last_dn;
    int last_cyc;

    always #5 clk = ~clk;

    cdr_period_track #(
        .W(W), .NOM(NOM), .MAX_DEV(MAX_DEV), .STEP(STEP), .VOTE_TH(VOTE_TH), .LOCK_N(LOCK_N)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_resync(resync),
        .i_T     (t_in),
        .i_E     (e_in),
        .o_nb_P  (nb_p),
        .o_sample(sample),
        .o_adj_up(adj_up),
        .o_adj_dn(adj_dn),
        .o_lock  (lock)
`ifdef CDR_TRACK_STATS_EN
        ,
        .o_adj_cnt(adj_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int sat_vote(input int v);
        return imax(-VOTE_TH, imin(VOTE_TH, v));
    endfunction

    task automatic model_clear();
        m_pos  = 0;
        m_p    = NOM;
        m_vote = 0;
        m_lock = 0;
        m_adj  = 0;
        cyc    = 0;
    endtask

    // One clock cycle: drive inputs, compare every output against the model, then advance both.
    task automatic tick(input bit tt, input bit ee, input bit rr);
        bit smp;
        bit want_up;
        bit want_dn;
        int np;
        int c;
        t_in   = tt;
        e_in   = ee;
        resync = rr;
        #1;
        smp     = (m_pos == m_p - 1);
        want_up = (m_vote >= VOTE_TH);
        want_dn = (m_vote <= -VOTE_TH);
        np      = m_p;
        if (smp && !rr) begin
            if (want_up)      np = imin(m_p + STEP, P_MAX);
            else if (want_dn) np = imax(m_p - STEP, P_MIN);
        end
        check("nb_p", nb_p, m_p);
        check("sample", sample, smp);
        check("adj_up", adj_up, np > m_p);
        check("adj_dn", adj_dn, np < m_p);
        check("lock", lock, m_lock >= LOCK_N);
`ifdef CDR_TRACK_STATS_EN
        check("adj_cnt", adj_cnt, m_adj);
`endif
        last_sample = smp;
        last_up     = (np > m_p);
        last_dn     = (np < m_p);
        last_cyc    = cyc + 1;
        @(posedge clk);
        c = tt ? (ee ? 1 : -1) : 0;
        if (rr) begin
            model_clear();
        end else begin
            if (np != m_p) m_adj = imin(m_adj + 1, 65535);
            if (smp) begin
                m_lock = (np != m_p) ? 0 : imin(m_lock + 1, LOCK_N);
                m_vote = (want_up || want_dn) ? c : sat_vote(m_vote + c);
                m_pos  = 0;
                m_p    = np;
            end else begin
                m_pos++;
                m_vote = sat_vote(m_vote + c);
            end
            cyc++;
        end
        #1;
    endtask

    task automatic run_to_strobe(input int budget, output int at, output bit su, output bit sd);
        at = -1;
        su = 1'b0;
        sd = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (last_sample) begin
                at = last_cyc;
                su = last_up;
                sd = last_dn;
                break;
            end
        end
        if (at < 0) check("strobe_timeout", 0, 1);
    endtask

    task automatic late_pair_then_late_on_strobe();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 22; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("dn_strobe_cycle", last_sample, 1);
        check("dn_pulse", last_dn, 1);
        check("dn_nb_p", nb_p, 24);
    endtask

    initial begin
        int at;
        int n_strobes;
        bit su;
        bit sd;
        bit ee;

        rst    = 1'b1;
        resync = 1'b0;
        t_in   = 1'b0;
        e_in   = 1'b0;
        model_clear();
        #12;
        check("rst_nb_p", nb_p, NOM);
        check("rst_sample", sample, 0);
        check("rst_adj_up", adj_up, 0);
        check("rst_adj_dn", adj_dn, 0);
        check("rst_lock", lock, 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle line: strobes every NOM cycles, lock after LOCK_N quiet strobes
        n_strobes = 0;
        for (int i = 0; i < 205; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (last_sample) begin
                n_strobes++;
                if (n_strobes <= 3) check("idle_strobe_cycle", last_cyc, 25 * n_strobes);
            end
        end
        check("idle_strobe_count", n_strobes, 8);
        check("idle_lock", lock, 1);
        check("idle_nb_p", nb_p, 25);

        // Two early votes in the first interval lengthen the period
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        run_to_strobe(40, at, su, sd);
        check("up_strobe_cycle", at, 25);
        check("up_pulse", su, 1);
        check("up_nb_p", nb_p, 26);
        check("up_lock", lock, 0);
        run_to_strobe(40, at, su, sd);
        check("up_next_strobe_cycle", at, 51);

        // Persistent early votes saturate at the upper bound
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b0);
            tick(1'b1, 1'b1, 1'b0);
            run_to_strobe(40, at, su, sd);
            check("max_nb_p", nb_p, (k == 0) ? 26 : 27);
            check("max_up_pulse", su, k < 2);
        end
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        run_to_strobe(40, at, su, sd);
        check("max_vote_cleared_dn", sd, 1);
        check("max_vote_cleared_nb_p", nb_p, 26);

        // Alternating early/late intervals never reach the threshold
        tick(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b1, (k % 2) == 0, 1'b0);
            run_to_strobe(40, at, su, sd);
            check("alt_no_adj", su || sd, 0);
        end
        check("alt_nb_p", nb_p, 25);
        check("alt_lock", lock, 1);

        // Late votes with a late transition on the strobe itself, then resync mid-interval
        late_pair_then_late_on_strobe();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check("resync_nb_p", nb_p, 25);
        check("resync_sample", sample, 0);
        check("resync_lock", lock, 0);
        check("resync_adj", adj_up || adj_dn, 0);
        run_to_strobe(40, at, su, sd);
        check("resync_strobe_cycle", at, 25);

        // Leftover -1 vote plus one more late vote moves the period again, then clamps at minimum
        late_pair_then_late_on_strobe();
        tick(1'b1, 1'b0, 1'b0);
        run_to_strobe(40, at, su, sd);
        check("carry_vote_dn", sd, 1);
        check("carry_vote_nb_p", nb_p, 23);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        run_to_strobe(40, at, su, sd);
        check("min_clamp_no_pulse", sd, 0);
        check("min_clamp_nb_p", nb_p, 23);

        // Asynchronous reset mid-interval drops the partial interval and pending votes
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_nb_p", nb_p, NOM);
        check("async_rst_sample", sample, 0);
        check("async_rst_lock", lock, 0);
        check("async_rst_adj", adj_up || adj_dn, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        run_to_strobe(40, at, su, sd);
        check("async_rst_strobe_cycle", at, 25);
        check("async_rst_votes_dropped", su, 0);

        // Biased random traffic with occasional resyncs
        tick(1'b0, 1'b0, 1'b1);
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                case (seg % 3)
                    0:       ee = ($urandom_range(0, 9) < 2);
                    1:       ee = ($urandom_range(0, 9) < 5);
                    default: ee = ($urandom_range(0, 9) < 8);
                endcase
                tick($urandom_range(0, 3) == 0, ee, $urandom_range(0, 299) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
